// File: rtl/rr_unrotate_issue_arbiter_9b.sv
// Round-robin issue arbiter over 9 slots: rotate-right, priority-encode, un-rotate to absolute slot.
// Latency: request to registered grant 1 cycle; ack to next grant 1 cycle, back-to-back with no bubble.
// Backpressure: grant held stable until grant_ack. Optional RR_ARB_GRANT_LOCK_EN adds grant_lock burst re-grant.
module rr_unrotate_issue_arbiter_9b #(
  parameter int NUM_REQ = 9,
  parameter int ID_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [8:0]      req,
  input  logic            grant_ack,
`ifdef RR_ARB_GRANT_LOCK_EN
  input  logic            grant_lock,
`endif
  output logic            grant_valid,
  output logic [8:0]      grant_onehot,
  output logic [ID_W-1:0] grant_id,
  output logic [ID_W-1:0] last_ptr
);

  generate
    if (NUM_REQ != 9 || ID_W != 4) begin : g_param_check
      $error("rr_unrotate_issue_arbiter_9b supports only NUM_REQ=9, ID_W=4");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state, state_n;
  logic            valid_n;
  logic [8:0]      onehot_n;
  logic [ID_W-1:0] id_n, ptr_n;

  logic [ID_W-1:0] start_base, start;
  logic [8:0]      rot, unrot;
  logic [ID_W-1:0] idx_r, pick_id;
  logic [ID_W:0]   id_sum;
  logic            lock_hit;

  // In GRANT the pointer about to be committed is grant_id, so the search starts just past it.
  always_comb begin
    start_base = (state == S_GRANT) ? grant_id : last_ptr;
    start      = (start_base >= ID_W'(8)) ? '0 : start_base + 1'b1;
  end

  always_comb begin
    rot = req;
    if (start[0]) rot = {rot[0],   rot[8:1]};
    if (start[1]) rot = {rot[1:0], rot[8:2]};
    if (start[2]) rot = {rot[3:0], rot[8:4]};
    if (start[3]) rot = {rot[7:0], rot[8]};

    idx_r = '0;
    for (int i = 8; i >= 0; i--) begin
      if (rot[i]) idx_r = ID_W'(i);
    end

    unrot = 9'd1 << idx_r;
    if (start[0]) unrot = {unrot[7:0], unrot[8]};
    if (start[1]) unrot = {unrot[6:0], unrot[8:7]};
    if (start[2]) unrot = {unrot[4:0], unrot[8:5]};
    if (start[3]) unrot = {unrot[0],   unrot[8:1]};

    id_sum  = {1'b0, idx_r} + {1'b0, start};
    pick_id = (id_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(id_sum - (ID_W+1)'(NUM_REQ))
                                             : id_sum[ID_W-1:0];
  end

`ifdef RR_ARB_GRANT_LOCK_EN
  assign lock_hit = grant_lock & req[grant_id];
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    valid_n  = grant_valid;
    onehot_n = grant_onehot;
    id_n     = grant_id;
    ptr_n    = last_ptr;
    case (state)
      S_IDLE: begin
        valid_n = 1'b0;
        if (|req) begin
          valid_n  = 1'b1;
          onehot_n = unrot;
          id_n     = pick_id;
          state_n  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (grant_ack && !lock_hit) begin
          ptr_n = grant_id;
          if (|req) begin
            onehot_n = unrot;
            id_n     = pick_id;
          end else begin
            valid_n  = 1'b0;
            onehot_n = '0;
            state_n  = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      grant_valid  <= 1'b0;
      grant_onehot <= '0;
      grant_id     <= '0;
      last_ptr     <= ID_W'(8);
    end else begin
      state        <= state_n;
      grant_valid  <= valid_n;
      grant_onehot <= onehot_n;
      grant_id     <= id_n;
      last_ptr     <= ptr_n;
    end
  end

endmodule

// File: tb/tb_rr_unrotate_issue_arbiter_9b.sv
// Bench for rr_unrotate_issue_arbiter_9b: directed scenarios with literal expectations plus random traffic
// against a modulo-search reference model checked every cycle.
module tb_rr_unrotate_issue_arbiter_9b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] req = '0;
  logic       grant_ack = 1'b0;
`ifdef RR_ARB_GRANT_LOCK_EN
  logic       grant_lock = 1'b0;
`endif
  logic       grant_valid;
  logic [8:0] grant_onehot;
  logic [3:0] grant_id;
  logic [3:0] last_ptr;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_valid = 0;
  int m_id    = 0;
  int m_ptr   = 8;

  rr_unrotate_issue_arbiter_9b #(.NUM_REQ(9), .ID_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant_ack    (grant_ack),
`ifdef RR_ARB_GRANT_LOCK_EN
    .grant_lock   (grant_lock),
`endif
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id),
    .last_ptr     (last_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // First requesting slot scanning upward from start, wrapping mod 9.
  function automatic int pick(input logic [8:0] r, input int start);
    for (int k = 0; k < 9; k++) begin
      if (r[(start + k) % 9]) return (start + k) % 9;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int lock;
`ifdef RR_ARB_GRANT_LOCK_EN
    lock = int'(grant_lock);
`else
    lock = 0;
`endif
    if (rst) begin
      m_valid = 0; m_id = 0; m_ptr = 8;
    end else if (m_valid == 0) begin
      if (req != 0) begin
        m_id = pick(req, (m_ptr + 1) % 9);
        m_valid = 1;
      end
    end else if (grant_ack) begin
      if (!(lock != 0 && req[m_id])) begin
        m_ptr = m_id;
        if (req != 0) m_id = pick(req, (m_id + 1) % 9);
        else m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_valid",  int'(grant_valid),  m_valid);
    check("cyc_onehot", int'(grant_onehot), (m_valid != 0) ? (1 << m_id) : 0);
    check("cyc_id",     int'(grant_id),     m_id);
    check("cyc_ptr",    int'(last_ptr),     m_ptr);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; grant_ack = 1'b0;
`ifdef RR_ARB_GRANT_LOCK_EN
    grant_lock = 1'b0;
`endif
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, then all requesting
    step(); step();
    check("rst_valid",  int'(grant_valid),  0);
    check("rst_onehot", int'(grant_onehot), 0);
    check("rst_id",     int'(grant_id),     0);
    check("rst_ptr",    int'(last_ptr),     8);
    rst = 1'b0; req = 9'h1FF;
    step();
    check("first_valid",  int'(grant_valid),  1);
    check("first_id",     int'(grant_id),     0);
    check("first_onehot", int'(grant_onehot), 9'h001);
    check("first_ptr",    int'(last_ptr),     8);
    check("model_first_id", m_id, 0);

    // Back-to-back acks walk every slot and wrap
    grant_ack = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      check("b2b_valid", int'(grant_valid), 1);
      check("b2b_id",    int'(grant_id),    k % 9);
    end
    check("model_b2b_ptr", m_ptr, 1);
    grant_ack = 1'b0;

    // Wrap past 7,8 from pointer 6
    do_reset();
    req = 9'h040;
    step();
    check("wrap_setup_id", int'(grant_id), 6);
    grant_ack = 1'b1; req = 9'b0_0010_0101;
    step();
    check("wrap_id0",  int'(grant_id), 0);
    check("wrap_ptr6", int'(last_ptr), 6);
    step();
    check("wrap_id2",  int'(grant_id), 2);
    step();
    check("wrap_id5",  int'(grant_id), 5);
    check("wrap_ptr2", int'(last_ptr), 2);
    grant_ack = 1'b0;

    // Hold without ack while req changes and drops
    do_reset();
    req = 9'h008;
    step();
    for (int i = 0; i < 5; i++) begin
      req = (i == 4) ? 9'h000 : ((i % 2) != 0 ? 9'h100 : 9'h008);
      step();
      check("hold_valid",  int'(grant_valid),  1);
      check("hold_id",     int'(grant_id),     3);
      check("hold_onehot", int'(grant_onehot), 9'h008);
    end
    grant_ack = 1'b1;
    step();
    check("drop_valid",  int'(grant_valid),  0);
    check("drop_onehot", int'(grant_onehot), 0);
    check("drop_ptr",    int'(last_ptr),     3);
    step();
    check("idle_ack_valid", int'(grant_valid), 0);
    check("idle_ack_ptr",   int'(last_ptr),    3);
    grant_ack = 1'b0;

    // Reset in the middle of a grant
    do_reset();
    req = 9'h010;
    step();
    check("midrst_pre_id", int'(grant_id), 4);
    rst = 1'b1;
    step();
    check("midrst_valid",  int'(grant_valid),  0);
    check("midrst_onehot", int'(grant_onehot), 0);
    check("midrst_ptr",    int'(last_ptr),     8);
    rst = 1'b0;
    step();
    check("midrst_regrant_valid", int'(grant_valid), 1);
    check("midrst_regrant_id",    int'(grant_id),    4);

`ifdef RR_ARB_GRANT_LOCK_EN
    do_reset();
    req = 9'h004;
    step();
    check("lock_setup_id", int'(grant_id), 2);
    req = 9'h1FF; grant_ack = 1'b1; grant_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lock_id",  int'(grant_id), 2);
      check("lock_ptr", int'(last_ptr), 8);
    end
    grant_lock = 1'b0;
    step();
    check("unlock_id",  int'(grant_id), 3);
    check("unlock_ptr", int'(last_ptr), 2);
    grant_lock = 1'b1; req = 9'h1F7;
    step();
    check("lock_noreq_id",  int'(grant_id), 4);
    check("lock_noreq_ptr", int'(last_ptr), 3);
    grant_ack = 1'b0; grant_lock = 1'b0;
`endif

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      case (mode)
        0:       req = '0;
        1:       req = 9'd1 << $urandom_range(0, 8);
        default: req = 9'($urandom);
      endcase
      grant_ack = ($urandom_range(0, 1) != 0);
      rst = ($urandom_range(0, 63) == 0);
`ifdef RR_ARB_GRANT_LOCK_EN
      grant_lock = ($urandom_range(0, 2) == 0);
`endif
      step();
    end
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
